writeback_unit: RTL

Producer side of the register-file write port. It collects completed results from the ALU and from the load path through valid/ready handshakes. Each source has its own small FIFO. The unit arbitrates between the two FIFOs and drives one registered write per cycle (wb_en/wb_addr/wb_data) into the 32x64 register file. Load data is size-adjusted and sign- or zero-extended here, and writes to x0 are filtered here.

---
 rtl/writeback_unit_if.sv | 49 ++++
 rtl/writeback_unit.sv | 131 +++++++++++++
 2 files changed

// File: rtl/writeback_unit_if.sv
// Bus bundle for writeback_unit: ALU and load result handshakes, register-file write port
// and idle status. The optional forwarding outputs exist only when WB_FWD_EN is defined.
interface writeback_unit_if #(
  parameter int unsigned BUS_DATA_WIDTH = 64
);
  logic                      alu_valid;
  logic                      alu_ready;
  logic [4:0]                alu_rd;
  logic [BUS_DATA_WIDTH-1:0] alu_result;

  logic                      ld_valid;
  logic                      ld_ready;
  logic [4:0]                ld_rd;
  logic [2:0]                ld_funct3;
  logic [BUS_DATA_WIDTH-1:0] ld_data;

  logic                      wb_en;
  logic [4:0]                wb_addr;
  logic [BUS_DATA_WIDTH-1:0] wb_data;
  logic                      idle;

`ifdef WB_FWD_EN
  logic                      fwd_valid;
  logic [4:0]                fwd_addr;
  logic [BUS_DATA_WIDTH-1:0] fwd_data;
`endif

  // Producer/observer side (ALU, load path, register file).
  modport master (
    output alu_valid, alu_rd, alu_result,
    output ld_valid, ld_rd, ld_funct3, ld_data,
    input  alu_ready, ld_ready,
    input  wb_en, wb_addr, wb_data, idle
`ifdef WB_FWD_EN
    , input fwd_valid, fwd_addr, fwd_data
`endif
  );

  // The writeback unit itself.
  modport slave (
    input  alu_valid, alu_rd, alu_result,
    input  ld_valid, ld_rd, ld_funct3, ld_data,
    output alu_ready, ld_ready,
    output wb_en, wb_addr, wb_data, idle
`ifdef WB_FWD_EN
    , output fwd_valid, fwd_addr, fwd_data
`endif
  );
endinterface

// File: rtl/writeback_unit.sv
// Register-file write-port producer. Buffers ALU and load results in per-source FIFOs,
// sign/zero-extends load data on entry, drops x0 writes, and arbitrates one registered
// write per cycle with a bounded load streak so waiting ALU results are not starved.
// Optional macro WB_FWD_EN adds combinational bypass outputs mirroring the current grant.
module writeback_unit #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned FIFO_DEPTH     = 2,
  parameter int unsigned MAX_LD_STREAK  = 4
) (
  input logic             clk,
  input logic             reset,
  writeback_unit_if.slave bus
);
  localparam int unsigned W       = BUS_DATA_WIDTH;
  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned StreakW = $clog2(MAX_LD_STREAK + 1);

  localparam logic [CntW-1:0]    CntFull   = CntW'(FIFO_DEPTH);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_LD_STREAK);

  typedef struct packed {
    logic [4:0]   rd;
    logic [W-1:0] data;
  } entry_t;

  // Size-adjust raw load data; 3'b111 behaves as a full doubleword.
  function automatic logic [W-1:0] ld_extend(input logic [2:0] f3, input logic [W-1:0] d);
    logic [W-1:0] r;
    case (f3)
      3'b000:  r = {{(W-8){d[7]}}, d[7:0]};
      3'b001:  r = {{(W-16){d[15]}}, d[15:0]};
      3'b010:  r = {{(W-32){d[31]}}, d[31:0]};
      3'b100:  r = {{(W-8){1'b0}}, d[7:0]};
      3'b101:  r = {{(W-16){1'b0}}, d[15:0]};
      3'b110:  r = {{(W-32){1'b0}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  entry_t alu_mem_q [FIFO_DEPTH];
  entry_t ld_mem_q  [FIFO_DEPTH];

  logic [PtrW-1:0]    alu_wptr_q, alu_rptr_q, ld_wptr_q, ld_rptr_q;
  logic [CntW-1:0]    alu_cnt_q, alu_cnt_d, ld_cnt_q, ld_cnt_d;
  logic [StreakW-1:0] streak_q, streak_d;
  logic               wb_en_q;
  logic [4:0]         wb_addr_q;
  logic [W-1:0]       wb_data_q;

  logic   alu_ready, ld_ready, alu_ne, ld_ne;
  logic   alu_push, ld_push, grant_alu, grant_ld, gnt_valid;
  entry_t gnt_entry;

  // Handshake, arbitration, FIFO counts and streak next-state.
  always_comb begin
    alu_ready = (alu_cnt_q != CntFull);
    ld_ready  = (ld_cnt_q != CntFull);
    alu_ne    = (alu_cnt_q != '0);
    ld_ne     = (ld_cnt_q != '0);

    // x0 transfers complete the handshake but are never stored.
    alu_push = bus.alu_valid && alu_ready && (bus.alu_rd != 5'd0);
    ld_push  = bus.ld_valid && ld_ready && (bus.ld_rd != 5'd0);

    grant_ld  = ld_ne && (!alu_ne || (streak_q != StreakMax));
    grant_alu = alu_ne && !grant_ld;
    gnt_valid = grant_ld || grant_alu;
    gnt_entry = grant_ld ? ld_mem_q[ld_rptr_q] : alu_mem_q[alu_rptr_q];

    alu_cnt_d = alu_cnt_q + CntW'(alu_push) - CntW'(grant_alu);
    ld_cnt_d  = ld_cnt_q + CntW'(ld_push) - CntW'(grant_ld);

    streak_d = streak_q;
    if (!alu_ne || grant_alu) begin
      streak_d = '0;
    end else if (grant_ld && (streak_q != StreakMax)) begin
      streak_d = streak_q + StreakW'(1);
    end
  end

  // Pointers, counts, streak and the registered write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_wptr_q <= '0;
      alu_rptr_q <= '0;
      ld_wptr_q  <= '0;
      ld_rptr_q  <= '0;
      alu_cnt_q  <= '0;
      ld_cnt_q   <= '0;
      streak_q   <= '0;
      wb_en_q    <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      alu_cnt_q <= alu_cnt_d;
      ld_cnt_q  <= ld_cnt_d;
      streak_q  <= streak_d;
      if (alu_push)  alu_wptr_q <= alu_wptr_q + PtrW'(1);
      if (ld_push)   ld_wptr_q  <= ld_wptr_q + PtrW'(1);
      if (grant_alu) alu_rptr_q <= alu_rptr_q + PtrW'(1);
      if (grant_ld)  ld_rptr_q  <= ld_rptr_q + PtrW'(1);
      wb_en_q <= gnt_valid;
      if (gnt_valid) begin
        wb_addr_q <= gnt_entry.rd;
        wb_data_q <= gnt_entry.data;
      end
    end
  end

  // FIFO storage; contents are only meaningful under the counts, so no reset is needed.
  always_ff @(posedge clk) begin
    if (alu_push) alu_mem_q[alu_wptr_q] <= '{rd: bus.alu_rd, data: bus.alu_result};
    if (ld_push)  ld_mem_q[ld_wptr_q]   <= '{rd: bus.ld_rd,
                                             data: ld_extend(bus.ld_funct3, bus.ld_data)};
  end

  assign bus.alu_ready = alu_ready;
  assign bus.ld_ready  = ld_ready;
  assign bus.wb_en     = wb_en_q;
  assign bus.wb_addr   = wb_addr_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.idle      = !alu_ne && !ld_ne && !wb_en_q;

`ifdef WB_FWD_EN
  assign bus.fwd_valid = gnt_valid && !reset;
  assign bus.fwd_addr  = gnt_entry.rd;
  assign bus.fwd_data  = gnt_entry.data;
`endif
endmodule
